// File: rtl/student_fir_out_conditioner_pkg.sv
// Shared sample type, clamp limits and saturating event-counter helper for
// the FIR output conditioner.
package student_fir_out_cond_pkg;

  localparam int unsigned CNT_W = 16;

  typedef logic signed [15:0] sample_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Event counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c, input logic ev);
    return (ev && (c != '1)) ? cnt_t'(c + 1'b1) : c;
  endfunction

endpackage

// File: rtl/student_fir_out_conditioner_if.sv
// FIR-result / IIS-slot bus of the output conditioner; the slave modport is
// the conditioner side.
interface student_fir_out_conditioner_if #(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned FIFO_DEPTH        = 8
);
  import student_fir_out_cond_pkg::*;

  logic [DATA_SIZE_FIR_OUT-1:0]      fir_data_i;
  logic                              fir_valid_i;
  logic [4:0]                        shift_i;
  logic                              sat_en_i;
  logic                              hold_last_i;
  logic                              frame_req_i;
  logic [DATA_SIZE_FIR_OUT-1:0]      data_o;
  logic                              valid_o;
  logic [$clog2(FIFO_DEPTH):0]       fill_o;
  cnt_t                              clip_cnt_o;
  cnt_t                              underflow_cnt_o;
  cnt_t                              overflow_cnt_o;

  modport master (
    output fir_data_i, fir_valid_i, shift_i, sat_en_i, hold_last_i, frame_req_i,
    input  data_o, valid_o, fill_o, clip_cnt_o, underflow_cnt_o, overflow_cnt_o
  );

  modport slave (
    input  fir_data_i, fir_valid_i, shift_i, sat_en_i, hold_last_i, frame_req_i,
    output data_o, valid_o, fill_o, clip_cnt_o, underflow_cnt_o, overflow_cnt_o
  );

endinterface

// File: rtl/student_fir_out_conditioner_fifo.sv
// Single-clock sample FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module student_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill    = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/student_fir_out_conditioner.sv
// Rounds/shifts/saturates the FIR accumulator into 16-bit samples and serves
// them from a FIFO on each IIS frame request, counting clip/under/overflow.
module student_fir_out_conditioner
  import student_fir_out_cond_pkg::*;
#(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned FIFO_DEPTH        = 8
) (
  input logic                          clk_i,
  input logic                          rst_i,
  student_fir_out_conditioner_if.slave bus
);

  localparam int unsigned EW = DATA_SIZE_FIR_OUT + 1;
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [EW-1:0] MAX_EXT = SAMPLE_MAX;
  localparam logic signed [EW-1:0] MIN_EXT = SAMPLE_MIN;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] s1_data;
  logic                 s1_valid;
  sample_t              s2_sample;
  logic                 clip_ev;
  sample_t              head;
  logic                 full;
  logic                 empty;
  logic [FW-1:0]        fill;
  sample_t              out_sample;
  logic                 overflow_ev;
  logic                 underflow_ev;

  // The extra MSB keeps ext + rounding constant from overflowing.
  always_comb begin
    ext = {bus.fir_data_i[DATA_SIZE_FIR_OUT-1], bus.fir_data_i};
    rnd = '0;
    if (bus.shift_i != '0) rnd[bus.shift_i - 5'd1] = 1'b1;
    rounded = ext + rnd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.fir_valid_i;
      if (bus.fir_valid_i) s1_data <= rounded >>> bus.shift_i;
    end
  end

  // Stage 2 is combinational into the FIFO; the FIFO entry is its register.
  always_comb begin
    s2_sample = s1_data[DATA_SIZE-1:0];
    clip_ev   = 1'b0;
    if (bus.sat_en_i) begin
      if (s1_data > MAX_EXT) begin
        s2_sample = SAMPLE_MAX;
        clip_ev   = s1_valid;
      end else if (s1_data < MIN_EXT) begin
        s2_sample = SAMPLE_MIN;
        clip_ev   = s1_valid;
      end
    end
  end

  student_sample_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (s1_valid),
    .wdata (s2_sample),
    .pop   (bus.frame_req_i),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign overflow_ev  = s1_valid && full && !bus.frame_req_i;
  assign underflow_ev = bus.frame_req_i && empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_sample          <= '0;
      bus.valid_o         <= 1'b0;
      bus.clip_cnt_o      <= '0;
      bus.underflow_cnt_o <= '0;
      bus.overflow_cnt_o  <= '0;
    end else begin
      bus.valid_o <= bus.frame_req_i;
      if (bus.frame_req_i) begin
        if (!empty)                out_sample <= head;
        else if (!bus.hold_last_i) out_sample <= '0;
      end
      bus.clip_cnt_o      <= sat_inc(bus.clip_cnt_o, clip_ev);
      bus.underflow_cnt_o <= sat_inc(bus.underflow_cnt_o, underflow_ev);
      bus.overflow_cnt_o  <= sat_inc(bus.overflow_cnt_o, overflow_ev);
    end
  end

  assign bus.data_o = {out_sample, {(DATA_SIZE_FIR_OUT-DATA_SIZE){1'b0}}};
  assign bus.fill_o = fill;

endmodule

// File: tb/tb_student_fir_out_conditioner.sv
// Directed bench for the FIR output conditioner: rounding, saturation, FIFO
// overflow/underflow, simultaneous push/pop and mid-stream reset.
module tb_student_fir_out_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  student_fir_out_conditioner_if #(
    .DATA_SIZE         (16),
    .DATA_SIZE_FIR_OUT (32),
    .FIFO_DEPTH        (8)
  ) bus ();

  student_fir_out_conditioner #(
    .DATA_SIZE         (16),
    .DATA_SIZE_FIR_OUT (32),
    .FIFO_DEPTH        (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single sample; returns once it has been written into the FIFO.
  task automatic send_one(input logic [31:0] d);
    @(negedge clk);
    bus.fir_data_i  = d;
    bus.fir_valid_i = 1'b1;
    @(negedge clk);
    bus.fir_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic req_one();
    @(negedge clk);
    bus.frame_req_i = 1'b1;
    @(negedge clk);
    bus.frame_req_i = 1'b0;
  endtask

  // Back-to-back pushes of first, first+1, ... with shift 0.
  task automatic push_seq(input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fir_data_i  = 32'(first) + 32'(i);
      bus.fir_valid_i = 1'b1;
    end
    @(negedge clk);
    bus.fir_valid_i = 1'b0;
    @(negedge clk);
  endtask

  // Consecutive frame requests, each expected to return the next sample.
  task automatic pop_seq(input int n, input logic [15:0] first);
    logic [15:0] s;
    @(negedge clk);
    bus.frame_req_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) bus.frame_req_i = 1'b0;
      s = first + 16'(i);
      check($sformatf("pop_data[%0d]", i), bus.data_o, {s, 16'h0000});
      check($sformatf("pop_valid[%0d]", i), {31'd0, bus.valid_o}, 32'd1);
    end
  endtask

  initial begin
    bus.fir_data_i  = '0;
    bus.fir_valid_i = 1'b0;
    bus.shift_i     = 5'd0;
    bus.sat_en_i    = 1'b1;
    bus.hold_last_i = 1'b0;
    bus.frame_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_data",  bus.data_o, 32'h0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_fill",  {28'd0, bus.fill_o}, 32'd0);
    check("rst_clip",  {16'd0, bus.clip_cnt_o}, 32'd0);
    check("rst_under", {16'd0, bus.underflow_cnt_o}, 32'd0);
    check("rst_over",  {16'd0, bus.overflow_cnt_o}, 32'd0);

    // Rounding: 1.5 -> 2, -1.5 -> -1
    bus.shift_i = 5'd15;
    send_one(32'h0000_C000);
    check("rnd_fill", {28'd0, bus.fill_o}, 32'd1);
    req_one();
    check("rnd_pos_data",  bus.data_o, 32'h0002_0000);
    check("rnd_pos_valid", {31'd0, bus.valid_o}, 32'd1);
    @(negedge clk);
    check("rnd_valid_drop", {31'd0, bus.valid_o}, 32'd0);
    send_one(32'hFFFF_4000);
    req_one();
    check("rnd_neg_data", bus.data_o, 32'hFFFF_0000);
    check("rnd_fill_empty", {28'd0, bus.fill_o}, 32'd0);

    // Saturation vs wrap
    bus.shift_i = 5'd0;
    send_one(32'h0001_0000);
    req_one();
    check("sat_data", bus.data_o, 32'h7FFF_0000);
    check("sat_clip", {16'd0, bus.clip_cnt_o}, 32'd1);
    bus.sat_en_i = 1'b0;
    send_one(32'h0001_0000);
    req_one();
    check("wrap_data", bus.data_o, 32'h0000_0000);
    check("wrap_clip", {16'd0, bus.clip_cnt_o}, 32'd1);
    bus.sat_en_i = 1'b1;
    send_one(32'hFFFE_0000);
    req_one();
    check("sat_neg_data", bus.data_o, 32'h8000_0000);
    check("sat_neg_clip", {16'd0, bus.clip_cnt_o}, 32'd2);

    // Overflow: 10 pushes into 8 entries
    push_seq(10, 16'h0001);
    check("ovf_fill",  {28'd0, bus.fill_o}, 32'd8);
    check("ovf_count", {16'd0, bus.overflow_cnt_o}, 32'd2);
    pop_seq(8, 16'h0001);
    check("ovf_drained", {28'd0, bus.fill_o}, 32'd0);
    check("ovf_no_under", {16'd0, bus.underflow_cnt_o}, 32'd0);

    // Underflow with hold-last, then with zero fill
    send_one(32'h0000_1234);
    req_one();
    bus.hold_last_i = 1'b1;
    req_one();
    check("udf_hold_data",  bus.data_o, 32'h1234_0000);
    check("udf_hold_valid", {31'd0, bus.valid_o}, 32'd1);
    check("udf_count1",     {16'd0, bus.underflow_cnt_o}, 32'd1);
    @(negedge clk);
    check("udf_valid_drop", {31'd0, bus.valid_o}, 32'd0);
    bus.hold_last_i = 1'b0;
    req_one();
    check("udf_zero_data", bus.data_o, 32'h0);
    check("udf_count2",    {16'd0, bus.underflow_cnt_o}, 32'd2);

    // Full FIFO: push and pop on the same edge
    push_seq(8, 16'h0021);
    check("full_fill", {28'd0, bus.fill_o}, 32'd8);
    @(negedge clk);
    bus.fir_data_i  = 32'h0000_0029;
    bus.fir_valid_i = 1'b1;
    @(negedge clk);
    bus.fir_valid_i = 1'b0;
    bus.frame_req_i = 1'b1;
    @(negedge clk);
    bus.frame_req_i = 1'b0;
    check("full_pp_fill", {28'd0, bus.fill_o}, 32'd8);
    check("full_pp_over", {16'd0, bus.overflow_cnt_o}, 32'd2);
    check("full_pp_data", bus.data_o, 32'h0021_0000);
    pop_seq(8, 16'h0022);

    // Empty FIFO: push and pop on the same edge, no bypass
    bus.hold_last_i = 1'b1;
    @(negedge clk);
    bus.fir_data_i  = 32'h0000_0077;
    bus.fir_valid_i = 1'b1;
    @(negedge clk);
    bus.fir_valid_i = 1'b0;
    bus.frame_req_i = 1'b1;
    @(negedge clk);
    bus.frame_req_i = 1'b0;
    check("empty_pp_under", {16'd0, bus.underflow_cnt_o}, 32'd3);
    check("empty_pp_fill",  {28'd0, bus.fill_o}, 32'd1);
    check("empty_pp_data",  bus.data_o, 32'h0029_0000);

    // Reset mid-stream with a sample in flight
    push_seq(4, 16'h0040);
    check("pre_rst_fill", {28'd0, bus.fill_o}, 32'd5);
    @(negedge clk);
    bus.fir_data_i  = 32'h0000_0055;
    bus.fir_valid_i = 1'b1;
    @(negedge clk);
    bus.fir_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data",  bus.data_o, 32'h0);
    check("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("mid_rst_fill",  {28'd0, bus.fill_o}, 32'd0);
    check("mid_rst_clip",  {16'd0, bus.clip_cnt_o}, 32'd0);
    check("mid_rst_under", {16'd0, bus.underflow_cnt_o}, 32'd0);
    check("mid_rst_over",  {16'd0, bus.overflow_cnt_o}, 32'd0);
    @(negedge clk);
    check("mid_rst_inflight", {28'd0, bus.fill_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
